// File: rtl/prng_arbiter.sv
// Round-robin front end that shares one PseudorandomGenerator between N requesters.
// Owns the LCG-advanced seed, sequences start/done handshakes and aborts hung draws.
module prng_arbiter #(
  parameter int          N            = 4,
  parameter logic [31:0] INIT_SEED    = 32'd2682981917,
  parameter int          START_CYCLES = 2,
  parameter int          TIMEOUT      = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [7:0]   rnd_value,
  output logic         rnd_valid,
  input  logic         reseed,
  input  logic [31:0]  reseed_value,
  output logic         busy,
  output logic         timeout_err,
  output logic         prg_start,
  output logic [31:0]  prg_seed,
  input  logic [7:0]   prg_value,
  input  logic         prg_done
);

  localparam int PW  = $clog2(N);
  localparam int SCW = $clog2(START_CYCLES + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] LCG_A = 32'd1664525;
  localparam logic [31:0] LCG_C = 32'd1013904223;

  typedef enum logic [1:0] {IDLE, START, WAIT, DELIVER} state_t;

  state_t        state_q, state_d;
  logic [31:0]   seed_q, seed_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [SCW-1:0] start_cnt_q, start_cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic          done_q;
  logic [7:0]    rnd_value_q, rnd_value_d;
  logic          timeout_err_q, timeout_err_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_val_q, pend_val_d;

  logic          req_found;
  logic [PW-1:0] req_pick;
  logic [PW-1:0] cand;
  logic          done_edge;
  logic [31:0]   seed_next;

  assign done_edge = prg_done & ~done_q;
  assign seed_next = seed_q * LCG_A + LCG_C;

  // Search upward from the slot after the last winner so every requester gets a turn.
  always_comb begin
    req_found = 1'b0;
    req_pick  = '0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = PW'((int'(rr_ptr_q) + i) % N);
      if (!req_found && req[cand]) begin
        req_found = 1'b1;
        req_pick  = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    seed_d        = seed_q;
    rr_ptr_d      = rr_ptr_q;
    cur_d         = cur_q;
    start_cnt_d   = start_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    rnd_value_d   = rnd_value_q;
    timeout_err_d = timeout_err_q;
    pend_d        = pend_q;
    pend_val_d    = pend_val_q;
    gnt           = '0;
    rnd_valid     = 1'b0;
    busy          = (state_q != IDLE);
    prg_start     = (state_q == START);

    // Reseeds arriving mid-draw wait for IDLE; a later pulse overwrites an earlier one.
    if (reseed && state_q != IDLE) begin
      pend_d     = 1'b1;
      pend_val_d = reseed_value;
    end

    unique case (state_q)
      IDLE: begin
        if (reseed || pend_q) begin
          seed_d        = reseed ? reseed_value : pend_val_q;
          timeout_err_d = 1'b0;
          pend_d        = 1'b0;
        end else if (req_found) begin
          cur_d       = req_pick;
          start_cnt_d = '0;
          state_d     = START;
        end
      end
      START: begin
        if (start_cnt_q == SCW'(START_CYCLES - 1)) begin
          start_cnt_d = '0;
          wait_cnt_d  = '0;
          state_d     = WAIT;
        end else begin
          start_cnt_d = start_cnt_q + SCW'(1);
        end
      end
      WAIT: begin
        if (done_edge) begin
          rnd_value_d = prg_value;
          seed_d      = seed_next;
          state_d     = DELIVER;
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          rnd_value_d   = 8'h00;
          timeout_err_d = 1'b1;
          seed_d        = seed_next;
          state_d       = DELIVER;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      DELIVER: begin
        rnd_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
          gnt[i] = (cur_q == PW'(i));
        end
        rr_ptr_d = cur_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      seed_q        <= INIT_SEED;
      rr_ptr_q      <= PW'(N - 1);
      cur_q         <= '0;
      start_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      done_q        <= 1'b0;
      rnd_value_q   <= 8'h00;
      timeout_err_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_val_q    <= '0;
    end else begin
      state_q       <= state_d;
      seed_q        <= seed_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_q         <= cur_d;
      start_cnt_q   <= start_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      done_q        <= prg_done;
      rnd_value_q   <= rnd_value_d;
      timeout_err_q <= timeout_err_d;
      pend_q        <= pend_d;
      pend_val_q    <= pend_val_d;
    end
  end

  assign rnd_value   = rnd_value_q;
  assign timeout_err = timeout_err_q;
  assign prg_seed    = seed_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Scoreboard bench for prng_arbiter: a behavioural PRG model answers draws, a
// reference model predicts grant order, seeds and values, and a monitor checks deliveries.
module tb_prng_arbiter;

  localparam int N            = 4;
  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 64;
  localparam logic [31:0] INIT_SEED = 32'd2682981917;
  localparam int M_NORMAL  = 0;
  localparam int M_STALE   = 1;
  localparam int M_TIMEOUT = 2;

  typedef struct {
    int         grantee;
    logic [7:0] value;
    logic       terr;
  } exp_t;

  typedef struct {
    int          mode;
    int          delay;
    int          hold;
    bit          level;
    logic [31:0] seed;
  } cfg_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [7:0]   rnd_value;
  logic         rnd_valid;
  logic         reseed;
  logic [31:0]  reseed_value;
  logic         busy;
  logic         timeout_err;
  logic         prg_start;
  logic [31:0]  prg_seed;
  logic [7:0]   prg_value;
  logic         prg_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_valid_cyc = 0;
  bit abort = 0;

  exp_t sb_q[$];
  cfg_t cfg_q[$];
  exp_t mon_e;
  cfg_t prg_c;
  logic [31:0] s0;
  int   scnt;
  bit   stable;

  logic [31:0] model_seed;
  logic        model_terr;
  int          last_grant;

  prng_arbiter #(
    .N(N), .INIT_SEED(INIT_SEED), .START_CYCLES(START_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .rnd_value(rnd_value),
    .rnd_valid(rnd_valid), .reseed(reseed), .reseed_value(reseed_value),
    .busy(busy), .timeout_err(timeout_err), .prg_start(prg_start),
    .prg_seed(prg_seed), .prg_value(prg_value), .prg_done(prg_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] prgFunc(input logic [31:0] s);
    return s[31:24] ^ s[15:8] ^ s[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] lcgNext(input logic [31:0] s);
    return s * 32'd1664525 + 32'd1013904223;
  endfunction

  function automatic int rrPick(input logic [N-1:0] pat, input int last);
    for (int i = 1; i <= N; i++) begin
      int c = (last + i) % N;
      if (pat[c]) return c;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every delivery strobe is matched against the oldest predicted draw.
  always @(negedge clk) begin
    if (rnd_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("gnt", 32'(gnt), 32'd1 << mon_e.grantee);
        checkOutput("rnd_value", 32'(rnd_value), 32'(mon_e.value));
        checkOutput("timeout_err", 32'(timeout_err), 32'(mon_e.terr));
        checkOutput("latency", 32'(cyc), 32'(exp_valid_cyc));
      end
    end else if (gnt != '0) begin
      checkOutput("gnt_without_valid", 32'(gnt), 32'd0);
    end
  end

  // Behavioural PseudorandomGenerator: done behaviour is chosen per draw by the stimulus.
  initial begin
    prg_done  = 1'b0;
    prg_value = 8'h00;
    forever begin
      @(negedge clk);
      if (prg_start) begin
        if (cfg_q.size() == 0) begin
          checkOutput("unexpected_start", 32'd1, 32'd0);
        end else begin
          prg_c = cfg_q.pop_front();
          checkOutput("prg_seed", prg_seed, prg_c.seed);
          s0 = prg_seed;
          stable = 1;
          if (prg_c.mode == M_STALE) begin
            prg_done  = 1'b1;
            prg_value = ~prgFunc(prg_seed);
          end
          scnt = 1;
          @(negedge clk);
          while (prg_start && scnt < 50) begin
            scnt++;
            if (prg_seed !== s0) stable = 0;
            @(negedge clk);
          end
          checkOutput("start_cycles", 32'(scnt), 32'(START_CYCLES));
          checkOutput("seed_stable", 32'(stable), 32'd1);
          if (prg_c.mode == M_TIMEOUT) begin
            prg_done = 1'b0;
            exp_valid_cyc = cyc + TIMEOUT;
          end else begin
            if (prg_c.mode == M_STALE) repeat (prg_c.hold) @(negedge clk);
            prg_done = 1'b0;
            repeat (prg_c.delay) @(negedge clk);
            prg_value = prgFunc(prg_seed);
            prg_done  = 1'b1;
            exp_valid_cyc = cyc + 1;
            if (!prg_c.level) begin
              @(negedge clk);
              prg_done = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic modelReset();
    model_seed = INIT_SEED;
    model_terr = 1'b0;
    last_grant = N - 1;
    sb_q.delete();
    cfg_q.delete();
  endtask

  task automatic idleCycles(input int n);
    req = '0;
    repeat (n) @(negedge clk);
  endtask

  // One complete draw; returns at the negedge where the delivery strobe is seen.
  task automatic applyStimulus(input logic [N-1:0] pat, input int mode, input int delay,
                               input int hold, input bit level, input bit pre,
                               input logic [31:0] pre_val, input bit mid,
                               input logic [31:0] mid_val);
    exp_t e;
    cfg_t c;
    bit seen;
    bit mid_done;
    if (abort) return;
    if (pre) begin
      model_seed   = pre_val;
      model_terr   = 1'b0;
      reseed       = 1'b1;
      reseed_value = pre_val;
    end
    req = pat;
    c.mode = mode; c.delay = delay; c.hold = hold; c.level = level; c.seed = model_seed;
    cfg_q.push_back(c);
    e.grantee = rrPick(pat, last_grant);
    e.value   = (mode == M_TIMEOUT) ? 8'h00 : prgFunc(model_seed);
    e.terr    = model_terr | (mode == M_TIMEOUT);
    sb_q.push_back(e);
    model_terr = e.terr;
    model_seed = lcgNext(model_seed);
    last_grant = e.grantee;
    if (mid) begin
      model_seed = mid_val;
      model_terr = 1'b0;
    end
    seen = 0;
    mid_done = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      reseed = 1'b0;
      if (rnd_valid) seen = 1;
      else if (mid && !mid_done && prg_start) begin
        reseed       = 1'b1;
        reseed_value = mid_val;
        mid_done     = 1;
      end
    end
    if (!seen) begin
      checkOutput("draw_bound", 32'd0, 32'd1);
      abort = 1;
    end
  endtask

  task automatic reseedIdle(input logic [31:0] v);
    reseed = 1'b1;
    reseed_value = v;
    @(negedge clk);
    reseed = 1'b0;
    model_seed = v;
    model_terr = 1'b0;
    checkOutput("terr_after_reseed", 32'(timeout_err), 32'd0);
    checkOutput("seed_after_reseed", prg_seed, v);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
    checkOutput({tag, "_valid"}, 32'(rnd_valid), 32'd0);
    checkOutput({tag, "_value"}, 32'(rnd_value), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_terr"}, 32'(timeout_err), 32'd0);
    checkOutput({tag, "_start"}, 32'(prg_start), 32'd0);
    checkOutput({tag, "_seed"}, prg_seed, INIT_SEED);
  endtask

  task automatic resetMidDraw();
    cfg_t c;
    bit ok;
    if (abort) return;
    req = 4'b0001;
    c.mode = M_TIMEOUT; c.delay = 0; c.hold = 0; c.level = 0; c.seed = model_seed;
    cfg_q.push_back(c);
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (prg_start) ok = 1;
    end
    for (int k = 0; k < 20 && ok && prg_start; k++) @(negedge clk);
    checkOutput("reached_wait", 32'(ok && busy && !prg_start), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    checkResetState("midreset");
    rst_n = 1'b1;
    modelReset();
    idleCycles(4);
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    reseed = 1'b0;
    reseed_value = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(4'b0001, M_NORMAL, 5, 0, 0, 0, 0, 0, 0);
    idleCycles(2);
    applyStimulus(4'b0100, M_NORMAL, 3, 0, 1, 1, 32'd0, 0, 0);
    applyStimulus(4'b0100, M_NORMAL, 4, 0, 1, 0, 0, 0, 0);
    idleCycles(1);
    checkOutput("seed_two_draws", prg_seed, 32'h47502932);

    applyStimulus(4'b1000, M_STALE, 4, 2, 1, 0, 0, 0, 0);
    applyStimulus(4'b0010, M_TIMEOUT, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(1);
    resetMidDraw();

    for (int i = 0; i < 5; i++)
      applyStimulus(4'b1111, M_NORMAL, $urandom_range(1, 6), 0, 1'($urandom_range(0, 1)), 0, 0, 0, 0);

    applyStimulus(4'b0010, M_TIMEOUT, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(1);
    reseedIdle(32'h0BADF00D);
    applyStimulus(4'b0100, M_NORMAL, 3, 0, 0, 0, 0, 1, 32'h12345678);
    applyStimulus(4'b0001, M_NORMAL, 2, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'b0010, M_NORMAL, 2, 0, 1, 1, 32'hCAFEF00D, 0, 0);

    for (int i = 0; i < 30; i++) begin
      int r = $urandom_range(0, 9);
      int m = (r == 0) ? M_TIMEOUT : (r == 1) ? M_STALE : M_NORMAL;
      bit pre = ($urandom_range(0, 7) == 0);
      bit mid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) idleCycles($urandom_range(1, 3));
      applyStimulus(N'($urandom_range(1, 15)), m, $urandom_range(1, 8), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), pre, $urandom, mid, $urandom);
    end

    idleCycles(5);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prng_arbiter.md
Name: prng_arbiter

Overview:
- Shares one PseudorandomGenerator instance between N requesters (selection, crossover, mutation units) using round-robin arbitration.
- Sequences each draw: presents the seed, pulses start, waits for done, then returns the 8-bit value to the granted requester.
- Owns the 32-bit seed register. Advances the seed with a 32-bit LCG after every draw so repeated draws differ. Supports runtime reseeding.
- Detects a hung generator with a timeout.

Parameters:
- N, 4, number of requesters (2..8).
- INIT_SEED, 32'd2682981917, seed register value after reset.
- START_CYCLES, 2, number of cycles prg_start is held high per draw (≥1).
- TIMEOUT, 64, maximum WAIT cycles before a draw is aborted (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- req  in  N  per-requester draw request (level).
- gnt  out  N  one-hot; high for exactly the cycle rnd_valid is high.
- rnd_value  out  8  drawn value; meaningful when rnd_valid=1.
- rnd_valid  out  1  single-cycle delivery strobe.
- reseed  in  1  pulse; load reseed_value into the seed register.
- reseed_value  in  32  new seed.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky flag; set on timeout; cleared by reset or by an applied reseed.
- prg_start  out  1  to PseudorandomGenerator.start.
- prg_seed  out  32  to PseudorandomGenerator.in_seed; always equals the seed register.
- prg_value  in  8  from PseudorandomGenerator.value.
- prg_done  in  1  from PseudorandomGenerator.done (may be level or pulse).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; seed=INIT_SEED; rr_ptr=N-1, so requester 0 has highest priority first.
  - gnt=0, rnd_value=0, rnd_valid=0, busy=0, timeout_err=0, prg_start=0, internal done_q=0, counters=0.
  - Reset mid-draw abandons the draw; nothing is delivered.
- States: IDLE, START, WAIT, DELIVER.
- IDLE:
  - A pending reseed is applied first: seed<=reseed_value, timeout_err<=0, stay IDLE one cycle.
  - Otherwise, if any req bit is high, grant the first set bit searching from rr_ptr+1 upward (mod N). Latch it as cur; go to START.
- START:
  - prg_start=1 for exactly START_CYCLES consecutive cycles; prg_seed stable throughout. Then go to WAIT with prg_start=0.
- WAIT:
  - Completion is a rising edge of prg_done (prg_done=1 and done_q=0, where done_q registers prg_done every cycle). This ignores a stale done level left from the previous draw.
  - On completion: capture prg_value into rnd_value; seed<=seed*32'd1664525+32'd1013904223 (mod 2^32); go to DELIVER.
  - If TIMEOUT WAIT cycles pass with no edge: rnd_value<=8'h00; timeout_err<=1; seed still advances; go to DELIVER.
- DELIVER (1 cycle):
  - rnd_valid=1, gnt=one-hot(cur), rr_ptr<=cur; next state IDLE.
  - An IDLE cycle always separates consecutive draws.
- Latency: req seen in IDLE at cycle t → prg_start high t+1..t+START_CYCLES → done edge sampled at cycle d → rnd_valid at d+1.
- Requester rules:
  - A requester holds req until it sees its gnt.
  - Dropping req after arbitration does not cancel the draw; the value is still delivered with that gnt.
  - Requesters must deassert req in the cycle after gnt, or they will be considered again.
- Reseed:
  - A reseed pulse while busy is latched into a pending flag together with its value. The last pulse wins.
  - It is applied in the next IDLE cycle, before arbitration.
  - A reseed in IDLE with req also high is applied first; arbitration occurs the following cycle.
- busy=1 in START, WAIT and DELIVER.

Test Plan:
- Reset, then req=4'b0001 with a model PRG whose done rises 5 cycles after start falls → prg_start high 2 cycles with prg_seed=2682981917. rnd_valid and gnt=0001 arrive 1 cycle after the done edge, with rnd_value = the model value.
- Reseed to 0, then two back-to-back draws by requester 2 → prg_seed is 0, then 0x3C6EF35F. Seed afterwards is 0x47502932. Two distinct rnd_value strobes, each with gnt=0100.
- req=4'b1111 held (each requester drops req after its gnt, then reasserts) → grant order 0,1,2,3,0 across five draws, with no starvation.
- Model PRG never raises done → after 64 WAIT cycles, rnd_valid=1, rnd_value=0x00, timeout_err=1. A subsequent reseed clears timeout_err.
- prg_done held high continuously from the previous draw → no premature completion. The next delivery waits for a fresh low-to-high edge.
- rst_n low during WAIT → all outputs 0 next cycle, no rnd_valid, seed=2682981917. reseed pulsed during START → applied only after DELIVER, and the next draw uses the new seed.
